user_gpio_out: RTL and testbench

Wishbone-slave GPIO register block in the Caravel user project area. Management-core firmware writes output values and output-enables for the 38 `mprj_io` pads and reads back pad inputs. The bring-up firmware checks the block by writing `0x00ABCDEF` so that `mprj_io[23:0]` shows `24'hABCDEF`.

---
 rtl/user_gpio_out.sv | 111 +++++++++++
 tb/tb_user_gpio_out.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/user_gpio_out.sv
// user_gpio_out: Wishbone-slave GPIO register block for the 38 mprj_io pads.
//
// Register map (word offsets from BASE_ADDR, decode on wbs_adr_i[31:8]):
//   0x00 DATA_LO  R/W  io_out[31:0]
//   0x04 DATA_HI  R/W  io_out[37:32] (bits [31:6] read 0)
//   0x08 OEB_LO   R/W  io_oeb[31:0]
//   0x0C OEB_HI   R/W  io_oeb[37:32]
//   0x10 IN_LO    RO   io_in[31:0]
//   0x14 IN_HI    RO   {26'b0, io_in[37:32]}
//   0x18 SET_LO   WO   DATA_LO |= wdata   (only with USER_GPIO_SETCLR_EN)
//   0x1C CLR_LO   WO   DATA_LO &= ~wdata  (only with USER_GPIO_SETCLR_EN)
//
// Optional feature macro: USER_GPIO_SETCLR_EN
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, async active-high reset
//   wbs_cyc_i/stb_i/we_i/sel_i  Wishbone request
//   wbs_adr_i, wbs_dat_i        byte address, write data
//   wbs_ack_o, wbs_dat_o        single-cycle ack, registered read data
//   io_in, io_out, io_oeb       pad inputs, outputs, active-low enables

module user_gpio_out #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   input  logic [37:0] io_in,
   output logic [37:0] io_out,
   output logic [37:0] io_oeb
);

   logic        r_ack;
   logic [31:0] r_dat;
   logic [37:0] r_data;
   logic [37:0] r_oeb;

   logic        w_hit;
   logic        w_accept;
   logic [5:0]  w_off;
   logic [31:0] w_mask;
   logic [31:0] w_wbits;
   logic [31:0] w_rdata;
   logic        w_unused_adr;

   assign w_hit        = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   // ~r_ack keeps a held strobe from being accepted on the ack cycle,
   // so ack can never be high two cycles running.
   assign w_accept     = wbs_cyc_i & wbs_stb_i & ~r_ack & w_hit;
   assign w_off        = wbs_adr_i[7:2];
   assign w_unused_adr = ^wbs_adr_i[1:0];

   assign w_mask  = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                     {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
   assign w_wbits = wbs_dat_i & w_mask;

   always_comb begin
      w_rdata = 32'h0;
      case (w_off)
         6'h00:   w_rdata = r_data[31:0];
         6'h01:   w_rdata = {26'h0, r_data[37:32]};
         6'h02:   w_rdata = r_oeb[31:0];
         6'h03:   w_rdata = {26'h0, r_oeb[37:32]};
         6'h04:   w_rdata = io_in[31:0];
         6'h05:   w_rdata = {26'h0, io_in[37:32]};
         default: w_rdata = 32'h0;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_ack  <= 1'b0;
         r_dat  <= 32'h0;
         r_data <= 38'h0;
         r_oeb  <= {38{1'b1}};
      end else begin
         r_ack <= w_accept;
         r_dat <= 32'h0;
         if (w_accept) begin
            if (wbs_we_i) begin
               case (w_off)
                  6'h00: r_data[31:0]  <= (r_data[31:0] & ~w_mask) | w_wbits;
                  6'h01: r_data[37:32] <= (r_data[37:32] & ~w_mask[5:0]) | w_wbits[5:0];
                  6'h02: r_oeb[31:0]   <= (r_oeb[31:0] & ~w_mask) | w_wbits;
                  6'h03: r_oeb[37:32]  <= (r_oeb[37:32] & ~w_mask[5:0]) | w_wbits[5:0];
`ifdef USER_GPIO_SETCLR_EN
                  6'h06: r_data[31:0]  <= r_data[31:0] | w_wbits;
                  6'h07: r_data[31:0]  <= r_data[31:0] & ~w_wbits;
`endif
                  default: ;
               endcase
            end else begin
               r_dat <= w_rdata;
            end
         end
      end
   end

   assign wbs_ack_o = r_ack;
   assign wbs_dat_o = r_dat;
   assign io_out    = r_data;
   assign io_oeb    = r_oeb;

endmodule

// File: tb/tb_user_gpio_out.sv
module tb_user_gpio_out;

   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cyc = 1'b0;
   logic        stb = 1'b0;
   logic        we  = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] adr = 32'h0;
   logic [31:0] wdat = 32'h0;
   logic        ack;
   logic [31:0] rdat;
   logic [37:0] pin = 38'h0;
   logic [37:0] pout;
   logic [37:0] poeb;

   int checks   = 0;
   int failures = 0;

   // Reference state: the 38-bit pad output and output-enable vectors.
   logic [37:0] m_out;
   logic [37:0] m_oeb;

   user_gpio_out #(.BASE_ADDR(BASE)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_adr_i(adr), .wbs_dat_i(wdat),
      .wbs_ack_o(ack), .wbs_dat_o(rdat),
      .io_in(pin), .io_out(pout), .io_oeb(poeb)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] bytemask(input logic [3:0] s);
      logic [31:0] m;
      m = 32'h0;
      for (int b = 0; b < 4; b++)
         if (s[b]) m = m | (32'hFF << (8 * b));
      return m;
   endfunction

   function automatic logic [31:0] model_read(input logic [7:0] off);
      case (off)
         8'h00:   return m_out[31:0];
         8'h04:   return 32'(m_out[37:32]);
         8'h08:   return m_oeb[31:0];
         8'h0C:   return 32'(m_oeb[37:32]);
         8'h10:   return pin[31:0];
         8'h14:   return 32'(pin[37:32]);
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_write(input logic [7:0] off, input logic [3:0] s, input logic [31:0] d);
      logic [31:0] m;
      logic [63:0] full;
      m = bytemask(s);
      case (off)
         8'h00: m_out[31:0] = (m_out[31:0] & ~m) | (d & m);
         8'h04: begin
            full = {26'h0, m_out[37:32]};
            full[31:0] = (full[31:0] & ~m) | (d & m);
            m_out[37:32] = full[5:0];
         end
         8'h08: m_oeb[31:0] = (m_oeb[31:0] & ~m) | (d & m);
         8'h0C: begin
            full = {26'h0, m_oeb[37:32]};
            full[31:0] = (full[31:0] & ~m) | (d & m);
            m_oeb[37:32] = full[5:0];
         end
`ifdef USER_GPIO_SETCLR_EN
         8'h18: m_out[31:0] = m_out[31:0] | (d & m);
         8'h1C: m_out[31:0] = m_out[31:0] & ~(d & m);
`endif
         default: ;
      endcase
   endtask

   // One bus transaction: strobe just after an edge, sample just after the
   // next edge, then confirm ack and read data dropped one cycle later.
   task automatic xfer(input logic [31:0] a, input logic w, input logic [3:0] s,
                       input logic [31:0] d, output logic acked, output logic [31:0] rd);
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
      @(posedge clk); #1;
      acked = ack;
      rd    = rdat;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      check("ack_one_cycle", 64'(ack), 64'h0);
      check("dat_idle_zero", 64'(rdat), 64'h0);
   endtask

   task automatic do_txn(input string tag, input logic [31:0] a, input logic w,
                         input logic [3:0] s, input logic [31:0] d, output logic [31:0] rd);
      logic hit;
      logic acked;
      logic [31:0] exp_rd;
      hit    = (a[31:8] == BASE[31:8]);
      exp_rd = model_read(a[7:0]);
      xfer(a, w, s, d, acked, rd);
      check({tag, "_ack"}, 64'(acked), 64'(hit));
      if (hit && !w) check({tag, "_rdata"}, 64'(rd), 64'(exp_rd));
      if (hit && w) model_write(a[7:0], s, d);
      check({tag, "_io_out"}, 64'(pout), 64'(m_out));
      check({tag, "_io_oeb"}, 64'(poeb), 64'(m_oeb));
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] a;
      logic [7:0]  off;

      m_out = 38'h0;
      m_oeb = 38'h3F_FFFF_FFFF;

      // Reset
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("rst_io_out", 64'(pout), 64'h0);
      check("rst_io_oeb", 64'(poeb), 64'h3F_FFFF_FFFF);
      check("rst_ack", 64'(ack), 64'h0);
      check("rst_dat", 64'(rdat), 64'h0);
      do_txn("rd_oeb_lo_rst", BASE + 32'h08, 1'b0, 4'hF, 32'h0, rd);
      check("oeb_lo_rst_val", 64'(rd), 64'hFFFF_FFFF);

      // Firmware pattern
      do_txn("fw_oeb", BASE + 32'h08, 1'b1, 4'hF, 32'hFF00_0000, rd);
      do_txn("fw_data", BASE + 32'h00, 1'b1, 4'hF, 32'h00AB_CDEF, rd);
      check("fw_pads_out", 64'(pout[23:0]), 64'hAB_CDEF);
      check("fw_pads_oeb", 64'(poeb[23:0]), 64'h0);

      // Byte enables
      do_txn("be_wr", BASE + 32'h00, 1'b1, 4'b0100, 32'h1122_3344, rd);
      do_txn("be_rd", BASE + 32'h00, 1'b0, 4'hF, 32'h0, rd);
      check("be_data_lo", 64'(rd), 64'h0022_CDEF);
      do_txn("hi_wr", BASE + 32'h04, 1'b1, 4'hF, 32'hFFFF_FFFF, rd);
      do_txn("hi_rd", BASE + 32'h04, 1'b0, 4'hF, 32'h0, rd);
      check("hi_readback", 64'(rd), 64'h3F);

      // Input readback
      pin = 38'h25_1234_5678;
      do_txn("in_lo", BASE + 32'h10, 1'b0, 4'hF, 32'h0, rd);
      check("in_lo_val", 64'(rd), 64'h1234_5678);
      do_txn("in_hi", BASE + 32'h14, 1'b0, 4'hF, 32'h0, rd);
      check("in_hi_val", 64'(rd), 64'h25);
      do_txn("in_wr_ro", BASE + 32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF, rd);

      // Decode: unmapped in-window offset, then out-of-window address
      do_txn("unmap_wr", BASE + 32'h40, 1'b1, 4'hF, 32'hFFFF_FFFF, rd);
      do_txn("unmap_rd", BASE + 32'h40, 1'b0, 4'hF, 32'h0, rd);
      check("unmap_rd_zero", 64'(rd), 64'h0);
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h3100_0000; wdat = 32'h0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("oow_no_ack", 64'(ack), 64'h0);
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      check("oow_io_out", 64'(pout), 64'(m_out));

      // Held strobe: ack pattern 1,0,1
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE + 32'h08;
      @(posedge clk); #1; check("held_ack0", 64'(ack), 64'h1);
      @(posedge clk); #1; check("held_ack1", 64'(ack), 64'h0);
      @(posedge clk); #1; check("held_ack2", 64'(ack), 64'h1);
      cyc = 1'b0; stb = 1'b0;
      @(posedge clk); #1;

      // SET/CLR
      do_txn("sc_init", BASE + 32'h00, 1'b1, 4'hF, 32'h0000_00F0, rd);
      do_txn("sc_set", BASE + 32'h18, 1'b1, 4'hF, 32'h0000_000F, rd);
      do_txn("sc_clr", BASE + 32'h1C, 1'b1, 4'hF, 32'h0000_0030, rd);
      do_txn("sc_rd", BASE + 32'h00, 1'b0, 4'hF, 32'h0, rd);
`ifdef USER_GPIO_SETCLR_EN
      check("sc_result", 64'(rd), 64'hCF);
`else
      check("sc_result", 64'(rd), 64'hF0);
`endif
      do_txn("sc_set_rd", BASE + 32'h18, 1'b0, 4'hF, 32'h0, rd);
      check("sc_set_rd0", 64'(rd), 64'h0);

      // Randomized traffic against the model
      for (int n = 0; n < 60; n++) begin
         pin = {6'($urandom), 32'($urandom)};
         off = 8'($urandom_range(0, 10) * 4);
         if ($urandom_range(0, 7) == 0)
            a = 32'h3000_0100 + 32'($urandom_range(0, 255)) * 32'h100;
         else
            a = BASE + 32'(off);
         do_txn("rand", a, 1'($urandom), 4'($urandom), $urandom, rd);
      end

      // Reset mid-transaction: ack and registers clear at once, no ack later
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE; wdat = 32'h1234_5678;
      #2 rst = 1'b1;
      #1;
      check("mid_rst_ack", 64'(ack), 64'h0);
      check("mid_rst_out", 64'(pout), 64'h0);
      check("mid_rst_oeb", 64'(poeb), 64'h3F_FFFF_FFFF);
      @(posedge clk); #1;
      check("mid_rst_no_ack", 64'(ack), 64'h0);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      rst = 1'b0;
      m_out = 38'h0;
      m_oeb = 38'h3F_FFFF_FFFF;
      do_txn("post_rst_rd", BASE + 32'h00, 1'b0, 4'hF, 32'h0, rd);
      check("post_rst_data", 64'(rd), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout obs=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
